legv8_control_unit: RTL and testbench
=====================================

# legv8_control_unit

Multi-cycle sequencer for the LEGv8 64-bit datapath. Fetches 32-bit instructions over a request/acknowledge port, decodes them, and drives the datapath's 23-bit control word, constant and B-select for one execute cycle per instruction. It owns the PC and instruction register, and resolves branches from the datapath status outputs.

## Interface
- No parameters.
- clock  in  1  single system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- imem_req  out  1  fetch request; high throughout FETCH
- imem_addr  out  64  byte address of fetch, equals pc
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  32  instruction word
- control_word  out  23  {SA[4:0], SB[4:0], DA[4:0], RegWrite, MemWrite, FS[4:0], SD} to datapath
- constant  out  64  extended immediate to datapath
- b_sel  out  1  1 = datapath B operand is constant
- status  in  4  datapath flags: [0]=Z, [1]=N, [2]=C, [3]=V
- pc  out  64  current program counter
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  core stopped
- illegal  out  1  stop was caused by an undecodable instruction

## Operation
- States: FETCH, DECODE, EXECUTE, HALT.
- FETCH: imem_req=1. On imem_ack, latch imem_data into IR and go to DECODE.
- DECODE: fields and immediate are registered. IR==32'h0 goes to HALT with illegal=0. An unrecognised opcode goes to HALT with illegal=1. Anything else goes to EXECUTE.
- EXECUTE: control_word, constant and b_sel are valid. At the clock edge:
  - retire pulses.
  - pc updates.
  - The next state is FETCH.
- Outside EXECUTE: control_word=0 (no RegWrite/MemWrite), constant=0, b_sel=0.
- Decode (FS: ADD=00010, SUB=01010, AND=00000, ORR=00001):
  - R-type ADD/SUB/AND/ORR: SA=Rn, SB=Rm, DA=Rd, RegWrite=1, b_sel=0, SD=0.
  - ADDI/SUBI: SA=Rn, DA=Rd, RegWrite=1, b_sel=1, constant=zero-extended imm12.
  - LDUR: SA=Rn, DA=Rt, RegWrite=1, b_sel=1, FS=ADD, SD=1, constant=sign-extended imm9.
  - STUR: SA=Rn, SB=Rt, MemWrite=1, b_sel=1, FS=ADD, constant=sign-extended imm9.
  - CBZ/CBNZ: SA=31, SB=Rt, FS=ORR, no writes. Taken if status[0]==1 (CBZ) or status[0]==0 (CBNZ).
  - B: always taken, no datapath writes; the control word has only FS=ADD.
- pc update: next pc = pc + (sign-extended imm<<2) if taken (imm26 for B, imm19 for CB*), else pc+4. All 64-bit arithmetic wraps modulo 2^64.
- HALT: terminal. halted=1, no requests, outputs idle. Only reset exits.

## Timing
- Reset values:
  - State FETCH, pc=0, IR=0.
  - imem_req=0 while reset is high, then 1 in the first cycle after release.
  - retire=0, halted=0, illegal=0, control_word=0.
- Latency: FETCH lasts ≥1 cycle. imem_ack is legal in the first FETCH cycle, giving a 3-cycle minimum per instruction.
- imem_ack outside FETCH is ignored. imem_data is sampled only on the ack cycle.
- Branch condition uses status combinationally during EXECUTE. The datapath RAM acts on the falling clock edge, so load and store complete inside EXECUTE.
- Reset mid-fetch or mid-execute aborts immediately, with no retire. Any write already in flight on the datapath is not masked retroactively.

## Configuration
- LEGV8_FLAGS_BCOND_EN defined:
  - ADDS/SUBS are added (as ADD/SUB), and capture status into a 4-bit NZCV register at the EXECUTE edge. The register resets to 0.
  - B.cond (imm19, cond[3:0]) evaluates the ARM condition set EQ..AL against the flags register. cond=1111 is illegal.
- Undefined: ADDS, SUBS and B.cond opcodes decode as illegal and go to HALT, illegal=1. No flags register exists.

## Structure
- Package legv8_pkg holds:
  - opcode constants (11/10/8/6-bit)
  - FS codes
  - state enum
  - status bit indices
  - control-word field widths and offsets
- Sub-module legv8_decoder (combinational IR → control fields, immediate, branch type, illegal). It is instantiated once; the FSM, pc and flags stay in the top module.

## Test plan
- Reset, then ADDI X1,X31,#5 with immediate ack → EXECUTE has SA=31, DA=1, b_sel=1, constant=5, RegWrite=1; retire on cycle 3; pc=4.
- STUR X2,[X1,#-8] → constant=64'hFFFF_FFFF_FFFF_FFF8, MemWrite=1, SB=2, RegWrite=0.
- CBZ X3,#-2 at pc=0x40, status[0]=1 → pc=0x38. Repeat with status[0]=0 → pc=0x44.
- imem_ack delayed 4 cycles, then reset asserted in the 2nd FETCH cycle → imem_req drops, pc=0, no retire, and fetch restarts at 0 after release.
- Word 0x00000000 → halted=1, illegal=0, imem_req stays 0. Word 0xFFFFFFFF → halted=1, illegal=1.
- With LEGV8_FLAGS_BCOND_EN: SUBS with status=4'b0001, then B.EQ #3 at pc=0x10 → pc=0x1C. Without the macro, the same B.EQ → illegal=1.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 control-unit definitions: opcodes, ALU function codes, FSM states,
// status bit positions, control-word layout and the branch-condition helper.
package legv8_pkg;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_ADDS = 11'h558;
  localparam logic [10:0] OP_SUBS = 11'h758;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [9:0]  OP_SUBI = 10'h344;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [7:0]  OP_CBNZ = 8'hB5;
  localparam logic [7:0]  OP_BCOND = 8'h54;
  localparam logic [5:0]  OP_B    = 6'h05;

  localparam logic [4:0] FS_ADD = 5'b00010;
  localparam logic [4:0] FS_SUB = 5'b01010;
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00001;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  localparam int STAT_Z = 0;
  localparam int STAT_N = 1;
  localparam int STAT_C = 2;
  localparam int STAT_V = 3;

  localparam int REG_W  = 5;
  localparam int FS_W   = 5;
  localparam int CW_W   = 23;
  localparam int CW_SD  = 0;
  localparam int CW_FS  = 1;
  localparam int CW_MW  = 6;
  localparam int CW_RW  = 7;
  localparam int CW_DA  = 8;
  localparam int CW_SB  = 13;
  localparam int CW_SA  = 18;

  localparam logic [2:0] BR_NONE   = 3'd0;
  localparam logic [2:0] BR_ALWAYS = 3'd1;
  localparam logic [2:0] BR_CBZ    = 3'd2;
  localparam logic [2:0] BR_CBNZ   = 3'd3;
  localparam logic [2:0] BR_COND   = 3'd4;

  function automatic logic [CW_W-1:0] pack_cw(
    input logic [REG_W-1:0] sa,
    input logic [REG_W-1:0] sb,
    input logic [REG_W-1:0] da,
    input logic             rw,
    input logic             mw,
    input logic [FS_W-1:0]  fs,
    input logic             sd
  );
    logic [CW_W-1:0] cw;
    cw = '0;
    cw[CW_SA +: REG_W] = sa;
    cw[CW_SB +: REG_W] = sb;
    cw[CW_DA +: REG_W] = da;
    cw[CW_RW]          = rw;
    cw[CW_MW]          = mw;
    cw[CW_FS +: FS_W]  = fs;
    cw[CW_SD]          = sd;
    return cw;
  endfunction

  // ARM condition codes; odd codes invert the even base test, except AL/NV.
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
    logic z, n, c, v, r;
    z = flags[STAT_Z];
    n = flags[STAT_N];
    c = flags[STAT_C];
    v = flags[STAT_V];
    case (cond[3:1])
      3'b000:  r = z;
      3'b001:  r = c;
      3'b010:  r = n;
      3'b011:  r = v;
      3'b100:  r = c & ~z;
      3'b101:  r = (n == v);
      3'b110:  r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    return (cond[0] && (cond[3:1] != 3'b111)) ? ~r : r;
  endfunction

endpackage

// File: rtl/legv8_decoder.sv
// Combinational LEGv8 instruction decoder: IR to control word, constant, branch info.
// ADDS/SUBS and B.cond are recognised only when LEGV8_FLAGS_BCOND_EN is defined.
module legv8_decoder
  import legv8_pkg::*;
(
  input  logic [31:0]     ir_i,
  output logic [CW_W-1:0] cw_o,
  output logic [63:0]     const_o,
  output logic            b_sel_o,
  output logic [2:0]      br_type_o,
  output logic [63:0]     br_off_o,
  output logic [3:0]      cond_o,
  output logic            set_flags_o,
  output logic            stop_o,
  output logic            illegal_o
);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [7:0]  op8;
  logic [5:0]  op6;
  logic [4:0]  rm, rn, rd;
  logic signed [63:0] imm9_sx, imm19_off, imm26_off;
  logic        is_r, r_set;
  logic [4:0]  r_fs;

  assign op11 = ir_i[31:21];
  assign op10 = ir_i[31:22];
  assign op8  = ir_i[31:24];
  assign op6  = ir_i[31:26];
  assign rm   = ir_i[20:16];
  assign rn   = ir_i[9:5];
  assign rd   = ir_i[4:0];

  // Branch offsets are word counts, hence the two appended zero bits.
  assign imm9_sx   = {{55{ir_i[20]}}, ir_i[20:12]};
  assign imm19_off = {{43{ir_i[23]}}, ir_i[23:5], 2'b00};
  assign imm26_off = {{36{ir_i[25]}}, ir_i[25:0], 2'b00};

  always_comb begin
    is_r  = 1'b1;
    r_set = 1'b0;
    r_fs  = FS_ADD;
    case (op11)
      OP_ADD: r_fs = FS_ADD;
      OP_SUB: r_fs = FS_SUB;
      OP_AND: r_fs = FS_AND;
      OP_ORR: r_fs = FS_ORR;
`ifdef LEGV8_FLAGS_BCOND_EN
      OP_ADDS: begin r_fs = FS_ADD; r_set = 1'b1; end
      OP_SUBS: begin r_fs = FS_SUB; r_set = 1'b1; end
`endif
      default: is_r = 1'b0;
    endcase
  end

  always_comb begin
    cw_o        = '0;
    const_o     = '0;
    b_sel_o     = 1'b0;
    br_type_o   = BR_NONE;
    br_off_o    = '0;
    cond_o      = ir_i[3:0];
    set_flags_o = 1'b0;
    stop_o      = 1'b0;
    illegal_o   = 1'b0;
    if (ir_i == 32'h0) begin
      stop_o = 1'b1;
    end else if (is_r) begin
      cw_o        = pack_cw(rn, rm, rd, 1'b1, 1'b0, r_fs, 1'b0);
      set_flags_o = r_set;
    end else if (op10 == OP_ADDI || op10 == OP_SUBI) begin
      cw_o    = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0,
                        (op10 == OP_SUBI) ? FS_SUB : FS_ADD, 1'b0);
      b_sel_o = 1'b1;
      const_o = {52'd0, ir_i[21:10]};
    end else if (op11 == OP_LDUR) begin
      cw_o    = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, FS_ADD, 1'b1);
      b_sel_o = 1'b1;
      const_o = imm9_sx;
    end else if (op11 == OP_STUR) begin
      cw_o    = pack_cw(rn, rd, 5'd0, 1'b0, 1'b1, FS_ADD, 1'b0);
      b_sel_o = 1'b1;
      const_o = imm9_sx;
    end else if (op8 == OP_CBZ || op8 == OP_CBNZ) begin
      cw_o      = pack_cw(XZR, rd, 5'd0, 1'b0, 1'b0, FS_ORR, 1'b0);
      br_type_o = (op8 == OP_CBZ) ? BR_CBZ : BR_CBNZ;
      br_off_o  = imm19_off;
    end else if (op6 == OP_B) begin
      cw_o      = pack_cw(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, FS_ADD, 1'b0);
      br_type_o = BR_ALWAYS;
      br_off_o  = imm26_off;
`ifdef LEGV8_FLAGS_BCOND_EN
    end else if (op8 == OP_BCOND && !ir_i[4] && ir_i[3:0] != 4'hF) begin
      cw_o      = pack_cw(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, FS_ADD, 1'b0);
      br_type_o = BR_COND;
      br_off_o  = imm19_off;
`endif
    end else begin
      illegal_o = 1'b1;
    end
  end

endmodule

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXECUTE/HALT, owns PC and IR.
// Define LEGV8_FLAGS_BCOND_EN to add ADDS/SUBS, the NZCV register and B.cond.
module legv8_control_unit
  import legv8_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [22:0] control_word,
  output logic [63:0] constant,
  output logic        b_sel,
  input  logic [3:0]  status,
  output logic [63:0] pc,
  output logic        retire,
  output logic        halted,
  output logic        illegal
);

  state_e          state_q, state_d;
  logic [63:0]     pc_q, pc_d;
  logic [31:0]     ir_q;
  logic [CW_W-1:0] cw_q;
  logic [63:0]     const_q, br_off_q;
  logic            bsel_q, illegal_q;
  logic [2:0]      br_type_q;
  logic            taken;

  logic [CW_W-1:0] dec_cw;
  logic [63:0]     dec_const, dec_br_off;
  logic            dec_bsel, dec_set_flags, dec_stop, dec_illegal;
  logic [2:0]      dec_br_type;
  logic [3:0]      dec_cond;

  legv8_decoder u_dec (
    .ir_i        (ir_q),
    .cw_o        (dec_cw),
    .const_o     (dec_const),
    .b_sel_o     (dec_bsel),
    .br_type_o   (dec_br_type),
    .br_off_o    (dec_br_off),
    .cond_o      (dec_cond),
    .set_flags_o (dec_set_flags),
    .stop_o      (dec_stop),
    .illegal_o   (dec_illegal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:   if (imem_ack) state_d = ST_DECODE;
      ST_DECODE:  state_d = (dec_stop || dec_illegal) ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: state_d = ST_FETCH;
      default:    state_d = ST_HALT;
    endcase
  end

  always_comb begin
    imem_req     = (state_q == ST_FETCH) && !reset;
    imem_addr    = pc_q;
    pc           = pc_q;
    retire       = (state_q == ST_EXECUTE) && !reset;
    halted       = (state_q == ST_HALT);
    illegal      = illegal_q;
    control_word = '0;
    constant     = '0;
    b_sel        = 1'b0;
    if (state_q == ST_EXECUTE) begin
      control_word = cw_q;
      constant     = const_q;
      b_sel        = bsel_q;
    end
  end

  // Decode results are captured at the DECODE edge and held through EXECUTE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      ir_q      <= '0;
      cw_q      <= '0;
      const_q   <= '0;
      bsel_q    <= 1'b0;
      br_type_q <= BR_NONE;
      br_off_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH:   if (imem_ack) ir_q <= imem_data;
        ST_DECODE: begin
          cw_q      <= dec_cw;
          const_q   <= dec_const;
          bsel_q    <= dec_bsel;
          br_type_q <= dec_br_type;
          br_off_q  <= dec_br_off;
          illegal_q <= dec_illegal;
        end
        ST_EXECUTE: pc_q <= pc_d;
        default: ;
      endcase
    end
  end

`ifdef LEGV8_FLAGS_BCOND_EN
  logic [3:0] flags_q;
  logic [3:0] cond_q;
  logic       set_flags_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flags_q     <= '0;
      cond_q      <= '0;
      set_flags_q <= 1'b0;
    end else if (state_q == ST_DECODE) begin
      cond_q      <= dec_cond;
      set_flags_q <= dec_set_flags;
    end else if (state_q == ST_EXECUTE && set_flags_q) begin
      flags_q <= status;
    end
  end
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{dec_cond, dec_set_flags, status[3:1]};
`endif

  // CB* reads the live Z status; B.cond reads the registered flags.
  always_comb begin
    case (br_type_q)
      BR_ALWAYS: taken = 1'b1;
      BR_CBZ:    taken = status[STAT_Z];
      BR_CBNZ:   taken = !status[STAT_Z];
`ifdef LEGV8_FLAGS_BCOND_EN
      BR_COND:   taken = cond_holds(cond_q, flags_q);
`endif
      default:   taken = 1'b0;
    endcase
  end

  assign pc_d = taken ? (pc_q + br_off_q) : (pc_q + 64'd4);

endmodule

// File: tb/tb_legv8_control_unit.sv
// Scoreboard bench for legv8_control_unit: stimulus queues expected retire/halt
// events, a monitor pops and compares them as the DUT presents them.
module tb_legv8_control_unit;

  logic        clock, reset;
  logic        imem_req, imem_ack;
  logic [63:0] imem_addr, constant, pc;
  logic [31:0] imem_data;
  logic [22:0] control_word;
  logic        b_sel, retire, halted, illegal;
  logic [3:0]  status;

  legv8_control_unit dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .control_word(control_word),
    .constant(constant), .b_sel(b_sel), .status(status), .pc(pc),
    .retire(retire), .halted(halted), .illegal(illegal)
  );

  localparam logic [4:0] F_ADD = 5'b00010, F_SUB = 5'b01010, F_AND = 5'b00000, F_ORR = 5'b00001;

  typedef struct {
    bit          halt;
    logic [22:0] cw;
    logic [63:0] cst;
    logic        bsel;
    logic [63:0] pc;
    logic [63:0] npc;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   halt_seen = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [22:0] cw(input logic [4:0] sa, input logic [4:0] sb_, input logic [4:0] da,
                                     input logic rw, input logic mw, input logic [4:0] fs, input logic sd);
    return {sa, sb_, da, rw, mw, fs, sd};
  endfunction

  task automatic exp_ret(input logic [22:0] c, input logic [63:0] k, input logic bs,
                         input logic [63:0] p, input logic [63:0] np);
    exp_t e;
    e.halt = 0; e.cw = c; e.cst = k; e.bsel = bs; e.pc = p; e.npc = np; e.ill = 0;
    sb.push_back(e);
  endtask

  task automatic exp_halt(input logic ill);
    exp_t e;
    e.halt = 1; e.cw = '0; e.cst = '0; e.bsel = 0; e.pc = '0; e.npc = '0; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] w, input int dly, input logic [3:0] st);
    for (int i = 0; i < 20 && !imem_req; i++) begin
      @(posedge clock); #1;
    end
    chk("req_wait", {63'd0, imem_req}, 64'd1);
    if (imem_req) begin
      repeat (dly) begin @(posedge clock); #1; end
      status    = st;
      imem_data = w;
      imem_ack  = 1'b1;
      @(posedge clock); #1;
      imem_ack  = 1'b0;
      imem_data = 32'hDEAD_BEEF;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Monitor: consumes one queued expectation per retire pulse or halt entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        halt_seen = 0;
      end else if (retire) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_retire: got retire at pc %h expected none", pc);
        end else begin
          e = sb.pop_front();
          chk("kind_retire", {63'd0, e.halt}, 64'd0);
          chk("control_word", {41'd0, control_word}, {41'd0, e.cw});
          chk("constant", constant, e.cst);
          chk("b_sel", {63'd0, b_sel}, {63'd0, e.bsel});
          chk("pc_at_retire", pc, e.pc);
          @(posedge clock); #1;
          chk("next_pc", pc, e.npc);
        end
      end else if (halted && !halt_seen) begin
        halt_seen = 1;
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_halt: got halted=1 expected no halt");
        end else begin
          e = sb.pop_front();
          chk("kind_halt", {63'd0, e.halt}, 64'd1);
          chk("illegal", {63'd0, illegal}, {63'd0, e.ill});
        end
      end
    end
  end

  initial begin : stim
    reset = 1'b1; imem_ack = 1'b0; imem_data = '0; status = '0;
    @(negedge clock);
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_pc", pc, 64'd0);
    chk("rst_retire", {63'd0, retire}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_illegal", {63'd0, illegal}, 64'd0);
    chk("rst_cw", {41'd0, control_word}, 64'd0);
    chk("rst_bsel", {63'd0, b_sel}, 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("req_after_release", {63'd0, imem_req}, 64'd1);
    chk("addr_after_release", imem_addr, 64'd0);

    // ADDI X1,X31,#5 with immediate ack: DECODE then EXECUTE (retire in cycle 3)
    exp_ret(cw(31, 0, 1, 1, 0, F_ADD, 0), 64'd5, 1, 64'h0, 64'h4);
    issue({10'h244, 12'd5, 5'd31, 5'd1}, 0, 4'h0);
    @(negedge clock); chk("cyc2_retire", {63'd0, retire}, 64'd0);
    @(negedge clock); chk("cyc3_retire", {63'd0, retire}, 64'd1);

    exp_ret(cw(1, 2, 0, 0, 1, F_ADD, 0), 64'hFFFF_FFFF_FFFF_FFF8, 1, 64'h4, 64'h8);
    issue({11'h7C0, 9'h1F8, 2'b00, 5'd1, 5'd2}, 2, 4'h0);
    exp_ret(cw(1, 2, 3, 1, 0, F_ADD, 0), 64'd0, 0, 64'h8, 64'hC);
    issue({11'h458, 5'd2, 6'd0, 5'd1, 5'd3}, 1, 4'h0);
    exp_ret(cw(1, 0, 4, 1, 0, F_ADD, 1), 64'd16, 1, 64'hC, 64'h10);
    issue({11'h7C2, 9'd16, 2'b00, 5'd1, 5'd4}, 0, 4'h0);
    exp_ret(cw(5, 0, 5, 1, 0, F_SUB, 0), 64'hFFF, 1, 64'h10, 64'h14);
    issue({10'h344, 12'hFFF, 5'd5, 5'd5}, 0, 4'h0);
    exp_ret(cw(7, 8, 6, 1, 0, F_ORR, 0), 64'd0, 0, 64'h14, 64'h18);
    issue({11'h550, 5'd8, 6'd0, 5'd7, 5'd6}, 0, 4'h0);
    exp_ret(cw(10, 11, 9, 1, 0, F_AND, 0), 64'd0, 0, 64'h18, 64'h1C);
    issue({11'h450, 5'd11, 6'd0, 5'd10, 5'd9}, 3, 4'h0);
    exp_ret(cw(13, 14, 12, 1, 0, F_SUB, 0), 64'd0, 0, 64'h1C, 64'h20);
    issue({11'h658, 5'd14, 6'd0, 5'd13, 5'd12}, 0, 4'h0);

    // Branches: B #8, CBZ taken/not-taken at 0x40, CBNZ taken/not-taken
    exp_ret(cw(0, 0, 0, 0, 0, F_ADD, 0), 64'd0, 0, 64'h20, 64'h40);
    issue({6'h05, 26'd8}, 0, 4'h0);
    exp_ret(cw(31, 3, 0, 0, 0, F_ORR, 0), 64'd0, 0, 64'h40, 64'h38);
    issue({8'hB4, 19'h7FFFE, 5'd3}, 0, 4'b0001);
    exp_ret(cw(0, 0, 0, 0, 0, F_ADD, 0), 64'd0, 0, 64'h38, 64'h40);
    issue({6'h05, 26'd2}, 0, 4'h0);
    exp_ret(cw(31, 3, 0, 0, 0, F_ORR, 0), 64'd0, 0, 64'h40, 64'h44);
    issue({8'hB4, 19'h7FFFE, 5'd3}, 0, 4'b0000);
    exp_ret(cw(31, 3, 0, 0, 0, F_ORR, 0), 64'd0, 0, 64'h44, 64'h54);
    issue({8'hB5, 19'd4, 5'd3}, 0, 4'b0000);
    exp_ret(cw(31, 3, 0, 0, 0, F_ORR, 0), 64'd0, 0, 64'h54, 64'h58);
    issue({8'hB5, 19'd4, 5'd3}, 0, 4'b0001);

    // Reset in the second cycle of a slow fetch
    for (int i = 0; i < 20 && !imem_req; i++) begin @(posedge clock); #1; end
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    chk("abort_req", {63'd0, imem_req}, 64'd0);
    chk("abort_pc", pc, 64'd0);
    chk("abort_retire", {63'd0, retire}, 64'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("refetch_req", {63'd0, imem_req}, 64'd1);
    chk("refetch_addr", imem_addr, 64'd0);

    // Wrap-around: B #-1 from 0, then B #4 from the top of the address space
    exp_ret(cw(0, 0, 0, 0, 0, F_ADD, 0), 64'd0, 0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    issue({6'h05, 26'h3FF_FFFF}, 0, 4'h0);
    exp_ret(cw(0, 0, 0, 0, 0, F_ADD, 0), 64'd0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hC);
    issue({6'h05, 26'd4}, 0, 4'h0);

`ifdef LEGV8_FLAGS_BCOND_EN
    exp_ret(cw(1, 2, 0, 1, 0, F_SUB, 0), 64'd0, 0, 64'hC, 64'h10);
    issue({11'h758, 5'd2, 6'd0, 5'd1, 5'd0}, 0, 4'b0001);
    exp_ret(cw(0, 0, 0, 0, 0, F_ADD, 0), 64'd0, 0, 64'h10, 64'h1C);
    issue({8'h54, 19'd3, 1'b0, 4'h0}, 0, 4'b0000);
`else
    exp_ret(cw(0, 0, 0, 0, 0, F_ADD, 0), 64'd0, 0, 64'hC, 64'h10);
    issue({6'h05, 26'd1}, 0, 4'h0);
    exp_halt(1'b1);
    issue({8'h54, 19'd3, 1'b0, 4'h0}, 0, 4'b0001);
    repeat (4) @(negedge clock);
    chk("bcond_halted", {63'd0, halted}, 64'd1);
`endif

    // Zero word halts cleanly and stops fetching
    do_reset();
    exp_halt(1'b0);
    issue(32'h0000_0000, 0, 4'h0);
    repeat (4) @(negedge clock);
    chk("zero_halted", {63'd0, halted}, 64'd1);
    chk("zero_illegal", {63'd0, illegal}, 64'd0);
    chk("zero_req", {63'd0, imem_req}, 64'd0);
    chk("zero_cw", {41'd0, control_word}, 64'd0);
    @(negedge clock);
    chk("zero_req_held", {63'd0, imem_req}, 64'd0);

    do_reset();
    exp_halt(1'b1);
    issue(32'hFFFF_FFFF, 1, 4'h0);
    repeat (4) @(negedge clock);
    chk("ones_halted", {63'd0, halted}, 64'd1);
    chk("ones_illegal", {63'd0, illegal}, 64'd1);
    chk("ones_req", {63'd0, imem_req}, 64'd0);

    repeat (3) @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
